// File: rtl/pipe_skid_reg_pkg.sv
`timescale 1ns/1ps
// pipe_skid_reg_pkg: shared types for pipeline stage registers.
// It holds the occupancy state enum, the stage payload structs and their
// bubble (NOP) constants. Stages size their pipe_skid_reg instance with
// $bits(<stage struct>) and pass the matching *_BUBBLE constant.
package pipe_skid_reg_pkg;

    // Occupancy of a stage register; the encoding equals the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // ---------------------------------------------------------------
    // EX stage payload
    // ---------------------------------------------------------------
    typedef enum logic [2:0] {
        ALU_OP_NONE = 3'd0,
        ALU_OP_ADD  = 3'd1,
        ALU_OP_SUB  = 3'd2,
        ALU_OP_AND  = 3'd3,
        ALU_OP_OR   = 3'd4,
        ALU_OP_XOR  = 3'd5,
        ALU_OP_SLL  = 3'd6,
        ALU_OP_SRL  = 3'd7
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic        wb_en;
    } ex_params_t;

    // An EX bubble performs no ALU operation and writes no register.
    localparam ex_params_t EX_PARAMS_BUBBLE = '{
        alu_op: ALU_OP_NONE,
        op_a:   32'd0,
        op_b:   32'd0,
        rd:     5'd0,
        wb_en:  1'b0
    };

    // ---------------------------------------------------------------
    // MEM stage payload
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } mem_size_t;

    typedef struct packed {
        mem_op_t     mem_op;
        mem_size_t   mem_size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } mem_params_t;

    // A MEM bubble issues no memory access.
    localparam mem_params_t MEM_PARAMS_BUBBLE = '{
        mem_op:   MEM_OP_NONE,
        mem_size: MEM_SIZE_W,
        addr:     32'd0,
        wdata:    32'd0,
        rd:       5'd0
    };

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg.sv
`timescale 1ns/1ps
// pipe_skid_reg: valid/ready pipeline stage register.
// SKID_EN=1 builds a two-entry skid buffer whose in_ready comes straight
// from a flop, cutting the out_ready -> in_ready timing path while still
// streaming one entry per cycle. SKID_EN=0 builds a plain single-entry
// register whose in_ready is combinational from out_ready.
// Held payload always reads as BUBBLE when no valid entry is present, so
// downstream logic sees a NOP without gating on out_valid.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned      WIDTH   = 64,
    parameter logic [WIDTH-1:0] BUBBLE  = '0,
    parameter bit               SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    if (SKID_EN) begin : g_skid

        pipe_state_t      state_q;
        logic             in_ready_q;
        logic             out_valid_q;
        logic [1:0]       count_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;

        logic accept;
        logic deliver;

        // Transfers are qualified only by flops and the partner's valid/ready,
        // so out_ready never reaches in_ready combinationally.
        assign accept  = in_valid && in_ready_q;
        assign deliver = out_valid_q && out_ready;

        // Occupancy FSM: moves entries between main and skid slots and
        // registers every output so all of them leave the block from flops.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (!rst_n) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b0;
                count_q     <= 2'd0;
                main_q      <= BUBBLE;
                // NOTE: the payload slots are reset too, because out_data must
                // read as BUBBLE straight out of reset and the skid slot feeds
                // main_q directly when the buffer drains.
                skid_q      <= BUBBLE;
            end else if (flush) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
                count_q     <= 2'd0;
                main_q      <= BUBBLE;
                skid_q      <= BUBBLE;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        // Also completes the first post-reset cycle, where
                        // in_ready_q is still low and nothing is accepted.
                        in_ready_q <= 1'b1;
                        if (accept) begin
                            state_q     <= BUSY;
                            out_valid_q <= 1'b1;
                            count_q     <= 2'd1;
                            main_q      <= in_data;
                        end
                    end

                    BUSY: begin
                        if (accept && !deliver) begin
                            // Downstream stalled: park the new entry in skid.
                            state_q    <= FULL;
                            in_ready_q <= 1'b0;
                            count_q    <= 2'd2;
                            skid_q     <= in_data;
                        end else if (!accept && deliver) begin
                            state_q     <= EMPTY;
                            out_valid_q <= 1'b0;
                            count_q     <= 2'd0;
                            main_q      <= BUBBLE;
                        end else if (accept && deliver) begin
                            // Streaming: main slot reloaded in place.
                            main_q <= in_data;
                        end
                    end

                    FULL: begin
                        // in_ready_q is low here, so only a drain can occur.
                        if (deliver) begin
                            state_q    <= BUSY;
                            in_ready_q <= 1'b1;
                            count_q    <= 2'd1;
                            main_q     <= skid_q;
                            skid_q     <= BUBBLE;
                        end
                    end

                    default: begin
                        // Unreachable encoding: recover to a clean empty state.
                        state_q     <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        count_q     <= 2'd0;
                        main_q      <= BUBBLE;
                        skid_q      <= BUBBLE;
                    end
                endcase
            end
        end

        assign in_ready  = in_ready_q;
        assign out_valid = out_valid_q;
        assign out_data  = main_q;
        assign count     = count_q;

    end else begin : g_single

        logic             valid_q;
        logic             rst_done_q;
        logic [WIDTH-1:0] data_q;

        logic ready;
        logic accept;
        logic deliver;

        // Accept when empty or when the held entry leaves this same cycle.
        // rst_done_q keeps in_ready low for the cycle following reset.
        assign ready   = rst_done_q && (!valid_q || out_ready);
        assign accept  = in_valid && ready;
        assign deliver = valid_q && out_ready;

        // Single-entry holding register; an accept overrides a concurrent
        // delivery because the new entry replaces the departing one.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q    <= 1'b0;
                rst_done_q <= 1'b0;
                data_q     <= BUBBLE;
            end else begin
                rst_done_q <= 1'b1;
                if (flush) begin
                    valid_q <= 1'b0;
                    data_q  <= BUBBLE;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    data_q  <= in_data;
                end else if (deliver) begin
                    valid_q <= 1'b0;
                    data_q  <= BUBBLE;
                end
            end
        end

        assign in_ready  = ready;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign count     = {1'b0, valid_q};

    end

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
`timescale 1ns/1ps
// tb_pipe_skid_reg: drives a skid (SKID_EN=1) and a single-entry (SKID_EN=0)
// instance with the same stimulus and compares both against queue-based
// reference models every cycle, plus directed expectations.
module tb_pipe_skid_reg;

    localparam int unsigned W   = 16;
    localparam logic [W-1:0] BUB = 16'hDEAD;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         s1_in_ready, s1_out_valid;
    logic [W-1:0] s1_out_data;
    logic [1:0]   s1_count;
    logic         s0_in_ready, s0_out_valid;
    logic [W-1:0] s0_out_data;
    logic [1:0]   s0_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID_EN(1'b1)) dut_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s1_in_ready),
        .in_data   (in_data),
        .out_valid (s1_out_valid),
        .out_ready (out_ready),
        .out_data  (s1_out_data),
        .count     (s1_count)
    );

    pipe_skid_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID_EN(1'b0)) dut_single (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s0_in_ready),
        .in_data   (in_data),
        .out_valid (s0_out_valid),
        .out_ready (out_ready),
        .out_data  (s0_out_data),
        .count     (s0_count)
    );

    // Reference models: held entries as FIFO queues with a capacity limit.
    logic [W-1:0] q1[$];
    bit           rdy1_m  = 1'b0;
    logic [W-1:0] q0[$];
    bit           done0_m = 1'b0;

    function automatic bit exp_rdy0();
        return done0_m && ((q0.size() == 0) || out_ready);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply one rising edge to the models using the pre-edge inputs.
    task automatic model_edge();
        bit acc1, del1, acc0, del0;
        if (!rst_n) begin
            q1.delete(); rdy1_m  = 1'b0;
            q0.delete(); done0_m = 1'b0;
        end else if (flush) begin
            q1.delete(); rdy1_m  = 1'b1;
            q0.delete(); done0_m = 1'b1;
        end else begin
            acc1 = in_valid && rdy1_m;
            del1 = (q1.size() != 0) && out_ready;
            acc0 = in_valid && exp_rdy0();
            del0 = (q0.size() != 0) && out_ready;
            if (del1) void'(q1.pop_front());
            if (acc1) q1.push_back(in_data);
            rdy1_m = (q1.size() < 2);
            if (del0) void'(q0.pop_front());
            if (acc0) q0.push_back(in_data);
            done0_m = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("s1_valid", s1_out_valid, 32'(q1.size() != 0));
        check("s1_data",  s1_out_data,  (q1.size() != 0) ? q1[0] : BUB);
        check("s1_count", s1_count,     32'(q1.size()));
        check("s1_ready", s1_in_ready,  rdy1_m);
        check("s0_valid", s0_out_valid, 32'(q0.size() != 0));
        check("s0_data",  s0_out_data,  (q0.size() != 0) ? q0[0] : BUB);
        check("s0_count", s0_count,     32'(q0.size()));
        check("s0_ready", s0_in_ready,  exp_rdy0());
    endtask

    // One clock: models advance at the edge, outputs compared at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_flush();
        flush = 1'b1; in_valid = 1'b0; step();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b0;

        // Reset held two cycles with a live input offered.
        step(); step();
        check("rst_valid", s1_out_valid, 0);
        check("rst_data",  s1_out_data,  BUB);
        check("rst_count", s1_count,     0);
        check("rst_ready_low", s1_in_ready, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        check("rst_ready_rise", s1_in_ready, 1);

        // Streaming: one entry per cycle, latency one.
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_data = W'(k);
            step();
            check("stream_valid", s1_out_valid, 1);
            check("stream_data",  s1_out_data,  k);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", s1_out_valid, 0);

        // Backpressure into FULL, then drain in order.
        idle_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0011; step();
        in_data = 16'h0022; step();
        check("bp_count", s1_count, 2);
        check("bp_ready", s1_in_ready, 0);
        in_data = 16'h0033; step();
        check("bp_hold_data",  s1_out_data, 16'h0011);
        check("bp_hold_count", s1_count, 2);
        out_ready = 1'b1;
        step(); check("bp_out2", s1_out_data, 16'h0022);
        step(); check("bp_out3", s1_out_data, 16'h0033);
        in_valid = 1'b0;
        step(); check("bp_empty", s1_out_valid, 0);

        // Flush in FULL discards held entries and the concurrent input.
        idle_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0011; step();
        in_data = 16'h0022; step();
        flush = 1'b1; in_data = 16'h0044; step();
        check("fl_count", s1_count, 0);
        check("fl_valid", s1_out_valid, 0);
        check("fl_data",  s1_out_data, BUB);
        check("fl_ready", s1_in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_no_44", s1_out_valid, 0);
        end

        // Reset in FULL behaves like flush but drops in_ready for a cycle.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0077; step();
        in_data = 16'h0088; step();
        check("rf_full", s1_count, 2);
        rst_n = 1'b0; step();
        check("rf_count", s1_count, 0);
        check("rf_data",  s1_out_data, BUB);
        check("rf_ready", s1_in_ready, 0);
        rst_n = 1'b1; in_valid = 1'b0; step();
        check("rf_ready_rise", s1_in_ready, 1);

        // Single-entry variant: combinational in_ready from out_ready.
        idle_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055; step();
        out_ready = 1'b1; in_data = 16'h0066; #1;
        check("s0_pass_ready", s0_in_ready, 1);
        step();
        check("s0_replaced", s0_out_data, 16'h0066);
        out_ready = 1'b0; in_data = 16'h0077; #1;
        check("s0_stall_ready", s0_in_ready, 0);
        step();
        check("s0_stall_data", s0_out_data, 16'h0066);

        // Random stall with occasional flush.
        idle_flush();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) == 0);
            in_data   = W'($urandom);
            #1;
            check("rnd_s1_ready", s1_in_ready, rdy1_m);
            check("rnd_s0_ready", s0_in_ready, exp_rdy0());
            out_ready = ~out_ready;
            #1;
            check("rnd_s1_ready_toggle", s1_in_ready, rdy1_m);
            check("rnd_s0_ready_toggle", s0_in_ready, exp_rdy0());
            out_ready = ~out_ready;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64: payload width in bits.
REQ-002 SHALL have parameter BUBBLE, default '0: payload driven when no valid entry is held (pipeline NOP).
REQ-003 SHALL have parameter SKID_EN, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single-entry register with combinational in_ready.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush  input  1  discard all held entries (branch/exception kill).
REQ-007 SHALL have port in_valid  input  1  upstream stage offers in_data.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  out_data is a live entry.
REQ-011 SHALL have port out_ready  input  1  downstream stage consumes out_data this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-013 SHALL have port count  output  2  number of held entries, 0..2.

Function
REQ-014 SHALL accept an input transfer when in_valid and in_ready are both 1 at a rising edge; SHALL complete an output transfer when out_valid and out_ready are both 1.
REQ-015 SHALL present an accepted entry on out_data with out_valid=1 exactly one cycle after acceptance when the block was empty (latency 1).
REQ-016 SHALL drive out_data = BUBBLE whenever out_valid = 0.
REQ-017 SHALL deliver entries in acceptance order, with no loss and no duplication.
REQ-018 With SKID_EN=1, SHALL implement states EMPTY (count 0), BUSY (count 1) and FULL (count 2).
REQ-019 With SKID_EN=1, SHALL apply these transitions: EMPTY + accept -> BUSY; BUSY + accept without output transfer -> FULL, with the new entry held in the skid slot; BUSY + output transfer without accept -> EMPTY; BUSY + accept + output transfer -> BUSY, main slot reloaded; FULL + output transfer -> BUSY, skid entry moved to main slot.
REQ-020 With SKID_EN=1, SHALL drive in_ready directly from a flop: in_ready = 1 in EMPTY and BUSY, 0 in FULL. There SHALL be no combinational path from out_ready to in_ready.
REQ-021 With SKID_EN=1, SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-022 With SKID_EN=0, SHALL drive in_ready = !out_valid || out_ready, use a single entry, and keep count at 0 or 1.
REQ-023 On flush=1 at a rising edge, SHALL go to EMPTY next cycle with count=0, out_valid=0 and out_data=BUBBLE, and SHALL discard any concurrent input transfer.
REQ-024 With SKID_EN=1, SHALL drive in_ready=1 in the cycle after a flush; with SKID_EN=0, in_ready in that cycle SHALL follow REQ-022.
REQ-025 SHALL ignore in_data when in_valid=0, and SHALL leave held entries unchanged when no transfer occurs (stall).
REQ-026 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.

Reset
REQ-027 While rst_n=0 at a rising edge, SHALL enter EMPTY with out_valid=0, out_data=BUBBLE, count=0, and skid contents cleared to BUBBLE.
REQ-028 While rst_n=0, in_ready SHALL be 0 in the next cycle; it SHALL rise in the first cycle after rst_n=1 is sampled.
REQ-029 Reset asserted mid-operation, including in FULL, SHALL discard all entries exactly as flush does.
REQ-030 rst_n SHALL take priority over flush, and flush SHALL take priority over transfers.

Structure
REQ-031 The state enum pipe_state_t (EMPTY, BUSY, FULL) SHALL live in the shared package types.
REQ-032 The per-stage bubble constants SHALL live in the shared package types, e.g. MEM_PARAMS_BUBBLE, a mem_params_t with mem_op = MEM_OP_NONE.
REQ-033 Pipeline stages (EX/MEM and others) SHALL instantiate pipe_skid_reg with WIDTH = $bits of the stage struct.
REQ-034 The block SHALL be a single module with no sub-module; the SKID_EN variants SHALL be selected by a generate branch.

Verification
REQ-035 Reset: rst_n=0 for 2 cycles with in_valid=1, in_data=0xAA -> out_valid=0, out_data=BUBBLE, count=0; in_ready=1 in the first cycle after release.
REQ-036 Streaming: SKID_EN=1, out_ready=1, in_valid=1 with data 1,2,3,...,10 on consecutive cycles -> out_data 1..10 on consecutive cycles, each one cycle after its input, no bubbles.
REQ-037 Backpressure: out_ready=0, push 0x11, 0x22, 0x33 -> count=2 and in_ready=0 after the second push, 0x33 not accepted; then out_ready=1 -> outputs 0x11, 0x22, 0x33 in order.
REQ-038 Flush in FULL: hold 0x11/0x22, assert flush together with in_valid=1, in_data=0x44 -> next cycle count=0, out_valid=0, out_data=BUBBLE; 0x44 never appears.
REQ-039 SKID_EN=0: out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 in the same cycle and out_data is replaced next cycle; with out_ready=0 -> in_ready=0.
REQ-040 Random stall: randomise in_valid and out_ready for 10k cycles, with flush at 1% of cycles -> scoreboard shows ordered, lossless delivery between flushes, and in_ready never changes in the same cycle as out_ready when SKID_EN=1.
